// File: rtl/replay_sequencer.sv
// Replays stored sensory/hippocampal/motor spike history as layer currents.
// Start/busy/done handshake, configurable timing, ordering, passes and abort.
module replay_sequencer #(
  parameter int N_L1       = 4,
  parameter int N_L2       = 8,
  parameter int N_L3       = 4,
  parameter int W_I        = 8,
  parameter int HIST_DEPTH = 8,
  parameter int CNT_W      = 16,
  parameter int HW         = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            rewarded,
  input  logic                            reverse,
  input  logic [HW-1:0]                   hist_count,
  input  logic [3:0]                      n_passes,
  input  logic [CNT_W-1:0]                window_len,
  input  logic [CNT_W-1:0]                step_len,
  input  logic [CNT_W-1:0]                rest_len,
  input  logic [3*W_I-1:0]                amp_r,
  input  logic [3*W_I-1:0]                amp_nr,
  input  logic [HIST_DEPTH*N_L1-1:0]      in_hist,
  input  logic [HIST_DEPTH*N_L2-1:0]      hippo_hist,
  input  logic [HIST_DEPTH*N_L3-1:0]      out_hist,
  output logic [(N_L1+N_L2+N_L3)*W_I-1:0] iin_replay,
  output logic                            busy,
  output logic                            learn_rest,
  output logic [HW-1:0]                   cur_entry,
  output logic                            done,
  output logic                            aborted
);

  localparam int IW = (N_L1 + N_L2 + N_L3) * W_I;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DRIVE, S_REST, S_DONE
  } state_t;

  state_t state, nstate;

  logic [CNT_W-1:0] timer, ntimer;
  logic [CNT_W-1:0] step_q, rest_q;
  logic [HW-1:0]    cnt_q, pos, npos, nent;
  logic [3:0]       pass, npass, passes_q;
  logic             rew_q, rev_q;
  logic             nabort, nlearn, adv;

  logic [HIST_DEPTH*N_L1-1:0] in_q;
  logic [HIST_DEPTH*N_L2-1:0] hip_q;
  logic [HIST_DEPTH*N_L3-1:0] out_q;

  logic                       idle;
  logic [HW-1:0]              cnt_in, c_cnt;
  logic [CNT_W-1:0]           c_step, c_rest, step_m1;
  logic [3:0]                 c_pass;
  logic                       c_rev, c_rew;
  logic [HIST_DEPTH*N_L1-1:0] s_in;
  logic [HIST_DEPTH*N_L2-1:0] s_hip;
  logic [HIST_DEPTH*N_L3-1:0] s_out;
  logic [3*W_I-1:0]           amp;
  logic [IW-1:0]              words;

  // Transitions out of IDLE see the live inputs; later ones see the latches.
  assign idle   = (state == S_IDLE);
  assign cnt_in = (hist_count > HW'(HIST_DEPTH)) ? HW'(HIST_DEPTH)
                                                 : hist_count;
  assign c_cnt  = idle ? cnt_in : cnt_q;
  assign c_step = idle ? step_len : step_q;
  assign c_rest = idle ? rest_len : rest_q;
  assign c_pass = idle ? n_passes : passes_q;
  assign c_rev  = idle ? reverse : rev_q;
  assign c_rew  = idle ? rewarded : rew_q;
  assign s_in   = idle ? in_hist : in_q;
  assign s_hip  = idle ? hippo_hist : hip_q;
  assign s_out  = idle ? out_hist : out_q;
  assign step_m1 = (c_step == '0) ? '0 : c_step - CNT_W'(1);
  assign amp    = c_rew ? amp_r : amp_nr;

  always_comb begin
    nstate = state;
    ntimer = timer;
    npos   = pos;
    npass  = pass;
    nabort = 1'b0;
    adv    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          npos  = '0;
          npass = '0;
          if (window_len != '0) begin
            nstate = S_WAIT;
            ntimer = window_len - CNT_W'(1);
          end else if (c_cnt != '0) begin
            nstate = S_DRIVE;
            ntimer = step_m1;
          end else begin
            nstate = S_DONE;
          end
        end
      end
      S_WAIT: begin
        if (abort) begin
          nstate = S_DONE;
          nabort = 1'b1;
        end else if (timer != '0) begin
          ntimer = timer - CNT_W'(1);
        end else if (c_cnt != '0) begin
          nstate = S_DRIVE;
          ntimer = step_m1;
        end else begin
          nstate = S_DONE;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          nstate = S_DONE;
          nabort = 1'b1;
        end else if (timer != '0) begin
          ntimer = timer - CNT_W'(1);
        end else if (c_rest != '0) begin
          nstate = S_REST;
          ntimer = c_rest - CNT_W'(1);
        end else begin
          adv = 1'b1;
        end
      end
      S_REST: begin
        if (abort) begin
          nstate = S_DONE;
          nabort = 1'b1;
        end else if (timer != '0) begin
          ntimer = timer - CNT_W'(1);
        end else begin
          adv = 1'b1;
        end
      end
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
    if (adv) begin
      if (pos + HW'(1) != c_cnt) begin
        nstate = S_DRIVE;
        npos   = pos + HW'(1);
        ntimer = step_m1;
      end else if ({1'b0, pass} + 5'd1 <
                   {1'b0, (c_pass == 4'd0) ? 4'd1 : c_pass}) begin
        nstate = S_DRIVE;
        npass  = pass + 4'd1;
        npos   = '0;
        ntimer = step_m1;
      end else begin
        nstate = S_DONE;
      end
    end
    if (nstate == S_DONE) ntimer = '0;
  end

  assign nlearn = ((nstate == S_DRIVE) && (ntimer == '0) &&
                   (c_rest == '0)) ||
                  ((state == S_DRIVE) && (nstate == S_REST));

  assign nent = c_rev ? npos : c_cnt - HW'(1) - npos;

  always_comb begin
    words = '0;
    if (int'(nent) < HIST_DEPTH) begin
      for (int k = 0; k < N_L1; k++)
        if (s_in[int'(nent)*N_L1 + k])
          words[k*W_I +: W_I] = amp[W_I-1:0];
      for (int k = 0; k < N_L2; k++)
        if (s_hip[int'(nent)*N_L2 + k])
          words[(N_L1+k)*W_I +: W_I] = amp[2*W_I-1:W_I];
      for (int k = 0; k < N_L3; k++)
        if (s_out[int'(nent)*N_L3 + k])
          words[(N_L1+N_L2+k)*W_I +: W_I] = amp[3*W_I-1:2*W_I];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      pos        <= '0;
      pass       <= '0;
      cnt_q      <= '0;
      step_q     <= '0;
      rest_q     <= '0;
      passes_q   <= '0;
      rew_q      <= 1'b0;
      rev_q      <= 1'b0;
      in_q       <= '0;
      hip_q      <= '0;
      out_q      <= '0;
      iin_replay <= '0;
      busy       <= 1'b0;
      learn_rest <= 1'b0;
      cur_entry  <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state <= nstate;
      timer <= ntimer;
      pos   <= npos;
      pass  <= npass;
      if (idle && start) begin
        cnt_q    <= cnt_in;
        step_q   <= step_len;
        rest_q   <= rest_len;
        passes_q <= n_passes;
        rew_q    <= rewarded;
        rev_q    <= reverse;
        in_q     <= in_hist;
        hip_q    <= hippo_hist;
        out_q    <= out_hist;
      end
      iin_replay <= (nstate == S_DRIVE) ? words : '0;
      busy       <= (nstate != S_IDLE);
      learn_rest <= nlearn;
      cur_entry  <= (nstate == S_DRIVE || nstate == S_REST) ? nent : '0;
      done       <= (nstate == S_DONE);
      aborted    <= nabort;
    end
  end

endmodule

// File: tb/tb_replay_sequencer.sv
// Randomised bench for replay_sequencer against a per-cycle schedule model.
// Directed timing cases plus random configs, aborts and ignored starts.
module tb_replay_sequencer;

  localparam int N_L1 = 4, N_L2 = 8, N_L3 = 4, W_I = 8;
  localparam int HD = 8, CNT_W = 16, HW = 4;
  localparam int IW = (N_L1 + N_L2 + N_L3) * W_I;

  logic clk = 1'b0;
  logic reset, start, abort, rewarded, reverse;
  logic [HW-1:0]        hist_count;
  logic [3:0]           n_passes;
  logic [CNT_W-1:0]     window_len, step_len, rest_len;
  logic [3*W_I-1:0]     amp_r, amp_nr;
  logic [HD*N_L1-1:0]   in_hist;
  logic [HD*N_L2-1:0]   hippo_hist;
  logic [HD*N_L3-1:0]   out_hist;
  logic [IW-1:0]        iin_replay;
  logic                 busy, learn_rest, done, aborted;
  logic [HW-1:0]        cur_entry;

  int checks = 0;
  int failures = 0;

  replay_sequencer #(
    .N_L1(N_L1), .N_L2(N_L2), .N_L3(N_L3), .W_I(W_I),
    .HIST_DEPTH(HD), .CNT_W(CNT_W), .HW(HW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rewarded(rewarded), .reverse(reverse), .hist_count(hist_count),
    .n_passes(n_passes), .window_len(window_len), .step_len(step_len),
    .rest_len(rest_len), .amp_r(amp_r), .amp_nr(amp_nr),
    .in_hist(in_hist), .hippo_hist(hippo_hist), .out_hist(out_hist),
    .iin_replay(iin_replay), .busy(busy), .learn_rest(learn_rest),
    .cur_entry(cur_entry), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit busy; bit done; bit ab; bit learn; bit drv;
    int entry; logic [IW-1:0] iin;
  } exp_t;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] model_iin(
      int e, logic [HD*N_L1-1:0] ih, logic [HD*N_L2-1:0] hh,
      logic [HD*N_L3-1:0] oh, logic [3*W_I-1:0] a);
    logic [IW-1:0] v = '0;
    for (int k = 0; k < N_L1; k++)
      if (ih[e*N_L1+k]) v[k*W_I +: W_I] = a[W_I-1:0];
    for (int k = 0; k < N_L2; k++)
      if (hh[e*N_L2+k]) v[(N_L1+k)*W_I +: W_I] = a[2*W_I-1:W_I];
    for (int k = 0; k < N_L3; k++)
      if (oh[e*N_L3+k]) v[(N_L1+N_L2+k)*W_I +: W_I] = a[3*W_I-1:2*W_I];
    return v;
  endfunction

  function automatic exp_t mk(bit b, bit d, bit ab, bit l, bit dv,
                              int e, logic [IW-1:0] v);
    exp_t x;
    x.busy = b; x.done = d; x.ab = ab; x.learn = l;
    x.drv = dv; x.entry = e; x.iin = v;
    return x;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_abrt"}, aborted, 0);
    chk({tag, "_learn"}, learn_rest, 0);
    chk({tag, "_entry"}, cur_entry, 0);
    chk({tag, "_iin"}, iin_replay, 0);
  endtask

  // One replay: builds the expected cycle-by-cycle schedule, then runs it.
  task automatic run(input bit rew, input bit rev, input int hc,
                     input int np, input int win, input int stp,
                     input int rst, input int abort_at, input bit poke,
                     output int done_at);
    exp_t q[$];
    logic [HD*N_L1-1:0] ih;
    logic [HD*N_L2-1:0] hh;
    logic [HD*N_L3-1:0] oh;
    logic [3*W_I-1:0]   a;
    int cnt, pn, sn, e, ab;
    ih = $urandom;
    hh = {$urandom, $urandom};
    oh = $urandom;
    amp_r  = 24'($urandom);
    amp_nr = 24'($urandom);
    a   = rew ? amp_r : amp_nr;
    cnt = (hc > HD) ? HD : hc;
    pn  = (np == 0) ? 1 : np;
    sn  = (stp == 0) ? 1 : stp;
    for (int i = 0; i < win; i++) q.push_back(mk(1, 0, 0, 0, 0, 0, '0));
    if (cnt > 0)
      for (int p = 0; p < pn; p++)
        for (int i = 0; i < cnt; i++) begin
          e = rev ? i : cnt - 1 - i;
          for (int s = 0; s < sn; s++)
            q.push_back(mk(1, 0, 0, (rst == 0) && (s == sn - 1), 1, e,
                           model_iin(e, ih, hh, oh, a)));
          for (int r = 0; r < rst; r++)
            q.push_back(mk(1, 0, 0, r == 0, 0, e, '0));
        end
    ab = 0;
    if (abort_at >= 1 && abort_at <= q.size()) begin
      while (q.size() > abort_at) void'(q.pop_back());
      ab = 1;
    end else begin
      abort_at = -1;
    end
    q.push_back(mk(1, 1, 1'(ab), 0, 0, 0, '0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, '0));

    @(negedge clk);
    rewarded = rew; reverse = rev;
    hist_count = HW'(hc); n_passes = 4'(np);
    window_len = CNT_W'(win); step_len = CNT_W'(stp);
    rest_len = CNT_W'(rst);
    in_hist = ih; hippo_hist = hh; out_hist = oh;
    start = 1'b1; abort = 1'b0;
    done_at = -1;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        rewarded = ~rew; reverse = ~rev;
        hist_count = HW'($urandom); n_passes = 4'($urandom);
        window_len = CNT_W'($urandom); step_len = CNT_W'($urandom);
        rest_len = CNT_W'($urandom);
        in_hist = $urandom; hippo_hist = {$urandom, $urandom};
        out_hist = $urandom;
      end
      chk("busy", busy, q[k].busy);
      chk("done", done, q[k].done);
      chk("aborted", aborted, q[k].ab);
      chk("learn_rest", learn_rest, q[k].learn);
      chk("iin_replay", iin_replay, q[k].iin);
      if (q[k].drv) chk("cur_entry", cur_entry, q[k].entry);
      if (done && done_at < 0) done_at = k + 1;
      abort = (k == abort_at - 1) || q[k].done;
      start = poke && q[k].busy && (k == 1 || q[k].done);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("stay_idle", busy, 0);
  endtask

  int d;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    rewarded = 1'b0; reverse = 1'b0; hist_count = '0; n_passes = '0;
    window_len = '0; step_len = '0; rest_len = '0;
    amp_r = '0; amp_nr = '0; in_hist = '0; hippo_hist = '0; out_hist = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;

    // Reset held mid-DRIVE returns to IDLE.
    @(negedge clk);
    hist_count = 4'd3; window_len = 16'd2; step_len = 16'd3;
    rest_len = 16'd1; n_passes = 4'd1; in_hist = '1;
    amp_r = 24'h030201; rewarded = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_idle("mid_reset");
    @(negedge clk);
    chk("post_reset_busy", busy, 0);

    run(1, 0, 3, 1, 2, 3, 1, -1, 0, d);
    chk("fwd_done_time", d, 15);
    run(0, 1, 3, 2, 2, 3, 1, -1, 1, d);
    chk("rev2_done_time", d, 27);
    run(1, 0, 12, 1, 1, 2, 1, -1, 0, d);
    chk("clamp_done_time", d, 26);
    run(1, 0, 0, 1, 4, 3, 1, -1, 0, d);
    chk("empty_done_time", d, 5);
    run(1, 0, 3, 1, 2, 3, 1, 8, 0, d);
    chk("abort_done_time", d, 9);
    run(0, 0, 4, 1, 0, 0, 0, -1, 1, d);
    chk("fast_done_time", d, 5);
    run(1, 1, 0, 0, 0, 0, 0, -1, 0, d);
    chk("null_done_time", d, 1);

    for (int r = 0; r < 24; r++)
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 12), $urandom_range(0, 3),
          $urandom_range(0, 4), $urandom_range(0, 4),
          $urandom_range(0, 3),
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : -1,
          1'($urandom_range(0, 1)), d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/replay_sequencer.md
Name: replay_sequencer

Overview:
- Parametrised successor of the single-pass hippocampal replay generator.
- After a trial, replays the stored input/hippocampus/motor spike-vector history as injected currents into all three network layers.
- Adds a start/busy/done handshake, a runtime-configurable window, step and rest lengths, and a variable history depth.
- Adds forward/reverse ordering, multiple passes and abort. Sits between the history buffers and the neuron-array current inputs.

Parameters:
- N_L1, 4, layer-1 (sensory) neuron count
- N_L2, 8, layer-2 (hippocampus) neuron count
- N_L3, 4, layer-3 (motor) neuron count
- W_I, 8, current word width
- HIST_DEPTH, 8, history entries stored (entry 0 = most recent)
- CNT_W, 16, width of timing counters and config lengths
- HW, 4, width of hist_count and cur_entry; must be >= clog2(HIST_DEPTH+1)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  request replay; sampled only in IDLE
- abort  in  1  terminate replay
- rewarded  in  1  selects R or NR amplitude set; latched at start
- reverse  in  1  0: oldest to newest; 1: newest to oldest; latched at start
- hist_count  in  HW  valid entries; latched at start; clamped to HIST_DEPTH
- n_passes  in  4  replay passes; 0 treated as 1
- window_len  in  CNT_W  quiet cycles before first step
- step_len  in  CNT_W  drive cycles per entry; 0 treated as 1
- rest_len  in  CNT_W  quiet cycles after each entry
- amp_r  in  3*W_I  rewarded amplitudes {motor, hippo, sensory}
- amp_nr  in  3*W_I  non-rewarded amplitudes, same packing
- in_hist  in  HIST_DEPTH*N_L1  entry h at [(h+1)*N_L1-1 -: N_L1]
- hippo_hist  in  HIST_DEPTH*N_L2  same packing
- out_hist  in  HIST_DEPTH*N_L3  same packing
- iin_replay  out  (N_L1+N_L2+N_L3)*W_I  {L3,L2,L1}; neuron k of a layer at [(k+1)*W_I-1 -: W_I]
- busy  out  1  high in every non-IDLE state
- learn_rest  out  1  one-cycle pulse on the first REST cycle of every entry
- cur_entry  out  HW  history index being driven
- done  out  1  one-cycle completion pulse
- aborted  out  1  valid with done; 1 if terminated by abort

Behaviour:
- Reset, and reset mid-operation: state IDLE; all outputs 0; counters 0; latches cleared.
- States: IDLE, WAIT, DRIVE, REST, DONE. All outputs are registered from the current state and counters.
- IDLE: start=1 at edge t latches rewarded, reverse, min(hist_count, HIST_DEPTH) -> cnt, the three history buses and config. Next state is WAIT; if window_len=0, next state is DRIVE.
- WAIT: occupies window_len cycles; iin_replay=0.
- cnt=0 at start: WAIT is still honoured, then DONE; no current is driven and learn_rest never pulses.
- Entry order:
  - forward: cnt-1 down to 0
  - reverse: 0 up to cnt-1
- DRIVE: occupies max(step_len,1) cycles. Each neuron word = amplitude of its layer if the latched bit of entry cur_entry is set, else 0. Amplitude set is amp_r if rewarded, else amp_nr. Amplitudes are sampled live.
- REST: occupies rest_len cycles; iin_replay=0; learn_rest=1 on its first cycle only.
- rest_len=0: REST is skipped and learn_rest pulses coincident with the last DRIVE cycle of the entry.
- Last entry of a pass:
  - if passes done < max(n_passes,1): the pass counter increments and DRIVE restarts at the first entry with no WAIT
  - otherwise the next state is DONE
- DONE: exactly one cycle; done=1, busy=1. Then IDLE with busy=0.
- abort=1 in WAIT/DRIVE/REST: next state DONE with aborted=1; iin_replay=0 from that cycle.
  - abort takes priority over every other transition.
  - abort in IDLE or DONE is ignored.
- start while busy is ignored; no queuing. start on the DONE cycle is ignored.
- Counters saturate-safe: config inputs other than amplitudes are latched at start, so mid-run changes have no effect.
- Widths: currents are passed through, never summed; no arithmetic overflow is possible.

Test Plan:
- Reset held 3 cycles mid-DRIVE -> next cycle iin_replay=0, busy=0, state IDLE; a new start replays from scratch.
- Forward replay, defaults, hist_count=3, window=2, step=3, rest=1, passes=1, rewarded=1, start at t0:
  - DRIVE entry 2 at t0+3..5, entry 1 at t0+7..9, entry 0 at t0+11..13
  - learn_rest at t0+6, 10, 14
  - done at t0+15, busy=0 at t0+16
  - active words = amp_r fields, inactive = 0
- Same stimulus with reverse=1, rewarded=0, n_passes=2 -> order 0,1,2,0,1,2; amp_nr values; 6 learn_rest pulses; done at t0+27.
- hist_count=12 (>HIST_DEPTH) -> clamped to 8 entries. hist_count=0, window=4 -> done at t0+5, iin_replay all 0, no learn_rest.
- abort at second DRIVE cycle of entry 1 -> next cycle done=1, aborted=1, iin_replay=0; following cycle busy=0.
- start pulsed while busy and on the DONE cycle -> ignored. step_len=0, rest_len=0 -> one cycle per entry, learn_rest on every DRIVE cycle.
